// File: rtl/fir_sample_feeder_pkg.sv
// fir_feeder_pkg: feeder FSM state type and underrun saturation limit
package fir_feeder_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, CAPT, HOLD} state_t;
    localparam logic [7:0] UNDERRUN_MAX = 8'hFF;
endpackage

// File: rtl/fir_sample_feeder_if.sv
// fir_sample_feeder_if: valid/ready sample stream with producer/consumer modports
interface fir_sample_feeder_if #(
    parameter int N = 16
) ();
    logic         valid;
    logic         ready;
    logic [N-1:0] data;
    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fir_sample_feeder_fifo.sv
// sync_fifo: single-clock FIFO, pointers carry an extra wrap bit to tell full from empty
module sync_fifo #(
    parameter int N = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [N-1:0] data_i,
    output logic [N-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [N-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = wr_q == rd_q;
    assign head_o  = mem_q[rd_q[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i && !full_o) wr_q <= wr_q + 1'b1;
            if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: paces buffered samples into a strobed FIR and streams the results
// FEEDER_UNDERRUN_CNT_EN enables the saturating empty-tick counter on underrun_cnt_o.
module fir_sample_feeder
    import fir_feeder_pkg::*;
#(
    parameter int N = 16,
    parameter int DEPTH = 4,
    parameter int DIV_W = 16,
    parameter int LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run_i,
    input  logic [DIV_W-1:0]    div_i,
    fir_sample_feeder_if.slave  s_if,
    output logic                fir_en_o,
    output logic [N-1:0]        fir_x_o,
    input  logic [N-1:0]        fir_y_i,
    fir_sample_feeder_if.master m_if,
    output logic                miss_o,
    output logic [7:0]          underrun_cnt_o
);
    localparam int LW = LAT > 1 ? $clog2(LAT) : 1;
    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_eff;
    logic [LW-1:0]    lat_q, lat_d;
    logic [N-1:0]     fir_x_q, fir_x_d, m_data_q, m_data_d, head;
    logic             fir_en_q, m_valid_q, m_valid_d, miss_q, miss_d, run_q, rdy_q;
    logic             full, empty, tick, issue, run_rise, lat_done;
    // The period length is latched at cnt==0 so a new div only applies from the next wrap
    assign div_eff  = (cnt_q == '0) ? div_i : div_q;
    assign tick     = run_i && (cnt_q == div_eff);
    assign cnt_d    = (!run_i || tick) ? '0 : cnt_q + 1'b1;
    assign run_rise = run_i && !run_q;
    assign issue    = tick && !empty && (state_q == IDLE);
    assign lat_done = lat_q == LW'(LAT - 1);
    assign miss_d   = (run_rise ? 1'b0 : miss_q) | (tick && (state_q != IDLE));
    assign fir_x_d  = issue ? head : fir_x_q;
    assign lat_d    = (state_q == WAIT && !lat_done) ? lat_q + 1'b1 : '0;
    sync_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (s_if.valid && s_if.ready),
        .pop_i  (issue),
        .data_i (s_if.data),
        .head_o (head),
        .full_o (full),
        .empty_o(empty)
    );
    always_comb begin
        state_d   = state_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        case (state_q)
            IDLE: state_d = issue ? WAIT : IDLE;
            WAIT: state_d = lat_done ? CAPT : WAIT;
            CAPT: begin
                m_data_d  = fir_y_i;
                m_valid_d = 1'b1;
                state_d   = HOLD;
            end
            HOLD: begin
                m_valid_d = !m_if.ready;
                state_d   = m_if.ready ? IDLE : HOLD;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            lat_q     <= '0;
            fir_x_q   <= '0;
            fir_en_q  <= 1'b0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            miss_q    <= 1'b0;
            run_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_eff;
            lat_q     <= lat_d;
            fir_x_q   <= fir_x_d;
            fir_en_q  <= issue;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            miss_q    <= miss_d;
            run_q     <= run_i;
            rdy_q     <= 1'b1;
        end
    end
    assign s_if.ready = rdy_q && !full;
    assign m_if.valid = m_valid_q;
    assign m_if.data  = m_data_q;
    assign fir_en_o   = fir_en_q;
    assign fir_x_o    = fir_x_q;
    assign miss_o     = miss_q;
`ifdef FEEDER_UNDERRUN_CNT_EN
    logic [7:0] ur_q, ur_base;
    logic       underrun;
    assign underrun = tick && empty && (state_q == IDLE);
    assign ur_base  = run_rise ? 8'd0 : ur_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ur_q <= '0;
        else        ur_q <= ur_base + 8'(underrun && (ur_base != UNDERRUN_MAX));
    end
    assign underrun_cnt_o = ur_q;
`else
    assign underrun_cnt_o = '0;
`endif
endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb_fir_sample_feeder: directed/random bench with a queue-based feeder model and a LAT=1 filter model
module tb_fir_sample_feeder;
    localparam int N = 16, DEPTH = 4, DIV_W = 16, LAT = 1;
    logic             clk = 0, rst_n = 0, run = 0;
    logic [DIV_W-1:0] div = '0;
    logic             fir_en, miss;
    logic [N-1:0]     fir_x, fir_y = '0;
    logic [7:0]       ucnt;
    int               vectors = 0, miscompares = 0, cyc = 0;
    int               en_cyc[$];
    logic [N-1:0]     en_x[$], got[$], mq[$];
    fir_sample_feeder_if #(.N(N)) s_if ();
    fir_sample_feeder_if #(.N(N)) m_if ();
    fir_sample_feeder #(.N(N), .DEPTH(DEPTH), .DIV_W(DIV_W), .LAT(LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run_i         (run),
        .div_i         (div),
        .s_if          (s_if),
        .fir_en_o      (fir_en),
        .fir_x_o       (fir_x),
        .fir_y_i       (fir_y),
        .m_if          (m_if),
        .miss_o        (miss),
        .underrun_cnt_o(ucnt)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [N-1:0] f(input logic [N-1:0] x);
        return x * 16'd3 + 16'h1357;
    endfunction
    // Filter model: Y is valid one edge after the edge that samples en
    always @(posedge clk) if (fir_en) fir_y <= f(fir_x);
    always @(negedge clk) begin
        if (fir_en) begin
            en_cyc.push_back(cyc);
            en_x.push_back(fir_x);
        end
        if (m_if.valid && m_if.ready) got.push_back(m_if.data);
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask
    task automatic push(input logic [N-1:0] d);
        bit ok = 0;
        s_if.valid = 1;
        s_if.data  = d;
        for (int i = 0; i < 200; i++) begin
            if (s_if.ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("push_accept", 32'(ok), 1);
        @(negedge clk);
        s_if.valid = 0;
        if (ok) mq.push_back(d);
    endtask
    task automatic clear_logs();
        en_cyc.delete();
        en_x.delete();
        got.delete();
        mq.delete();
    endtask
    task automatic check_stream(input string tag, input int n);
        chk({tag, "_en_n"}, en_x.size(), n);
        chk({tag, "_got_n"}, got.size(), n);
        for (int k = 0; k < n; k++) begin
            chk({tag, "_x"}, k < en_x.size() ? en_x[k] : 'x, mq[k]);
            chk({tag, "_y"}, k < got.size() ? got[k] : 'x, f(mq[k]));
        end
    endtask
    function automatic logic [7:0] ur(input int n);
`ifdef FEEDER_UNDERRUN_CNT_EN
        return n > 255 ? 8'd255 : 8'(n);
`else
        return 8'(0 * n);
`endif
    endfunction
    initial begin
        int c0, c1, c2, c3, c4, c5, c6, d;
        logic [N-1:0] d5, x;
        s_if.valid = 0;
        s_if.data  = '0;
        m_if.ready = 1;
        repeat (3) @(negedge clk);
        chk("rst_fir_en", fir_en, 0);
        chk("rst_fir_x", fir_x, 0);
        chk("rst_m_valid", m_if.valid, 0);
        chk("rst_m_data", m_if.data, 0);
        chk("rst_miss", miss, 0);
        chk("rst_ucnt", ucnt, 0);
        chk("rst_s_ready", s_if.ready, 0);
        rst_n = 1;
        @(negedge clk);
        chk("rst_s_ready_rel", s_if.ready, 1);
        // Fill the FIFO with no ticks, then hold a fifth sample until the first pop
        for (int i = 0; i < 4; i++) push(N'($urandom));
        chk("full_s_ready", s_if.ready, 0);
        d5 = N'($urandom);
        s_if.valid = 1;
        s_if.data  = d5;
        repeat (3) begin
            @(negedge clk);
            chk("full_hold", s_if.ready, 0);
        end
        div = 9;
        run = 1;
        c0  = cyc;
        for (int i = 0; i < 40; i++) begin
            if (s_if.ready) break;
            @(negedge clk);
        end
        chk("ready_rise_cyc", cyc, c0 + 10);
        @(negedge clk);
        s_if.valid = 0;
        mq.push_back(d5);
        while (cyc < c0 + 65) @(negedge clk);
        run = 0;
        repeat (2) @(negedge clk);
        check_stream("t1", 5);
        for (int k = 0; k < 5; k++) chk("t1_en_cyc", k < en_cyc.size() ? en_cyc[k] : -1, c0 + 10 + 10 * k);
        chk("t1_miss", miss, 0);
        chk("t1_ucnt", ucnt, ur(1));
        // Downstream stall: result must hold and later ticks are dropped
        clear_logs();
        push(N'($urandom));
        push(N'($urandom));
        m_if.ready = 0;
        div = 4;
        run = 1;
        c1  = cyc;
        while (cyc < c1 + 8) @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            if (i % 10 == 0) begin
                chk("t3_m_valid", m_if.valid, 1);
                chk("t3_m_data", m_if.data, f(mq[0]));
            end
            @(negedge clk);
        end
        chk("t3_en_n", en_cyc.size(), 1);
        chk("t3_en_cyc", en_cyc.size() > 0 ? en_cyc[0] : -1, c1 + 5);
        chk("t3_miss", miss, 1);
        m_if.ready = 1;
        repeat (20) @(negedge clk);
        run = 0;
        repeat (2) @(negedge clk);
        check_stream("t3", 2);
        // Empty FIFO ticks: underrun events only, miss cleared by run rising
        clear_logs();
        d   = $urandom_range(1, 5);
        div = DIV_W'(d);
        run = 1;
        c2  = cyc;
        while (cyc < c2 + 3 * (d + 1)) @(negedge clk);
        run = 0;
        @(negedge clk);
        chk("t4_en_n", en_cyc.size(), 0);
        chk("t4_miss", miss, 0);
        chk("t4_ucnt", ucnt, ur(3));
        // Async reset while the filter result is in flight
        clear_logs();
        push(N'($urandom));
        push(N'($urandom));
        div = 3;
        run = 1;
        c3  = cyc;
        for (int i = 0; i < 20; i++) begin
            if (fir_en) break;
            @(negedge clk);
        end
        chk("t5_en_cyc", cyc, c3 + 4);
        #2;
        rst_n = 0;
        run   = 0;
        #1;
        chk("t5_fir_en", fir_en, 0);
        chk("t5_m_valid", m_if.valid, 0);
        chk("t5_s_ready", s_if.ready, 0);
        chk("t5_ucnt", ucnt, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("t5_s_ready_rel", s_if.ready, 1);
        clear_logs();
        div = 1;
        run = 1;
        c5  = cyc;
        while (cyc < c5 + 6) @(negedge clk);
        run = 0;
        repeat (3) @(negedge clk);
        chk("t5_flushed", en_cyc.size(), 0);
        chk("t5_no_result", got.size(), 0);
        x = N'($urandom);
        push(x);
        div = 2;
        run = 1;
        c6  = cyc;
        while (cyc < c6 + 10) @(negedge clk);
        run = 0;
        repeat (2) @(negedge clk);
        check_stream("t5", 1);
        chk("t5_resume_cyc", en_cyc.size() > 0 ? en_cyc[0] : -1, c6 + 3);
        // div=0 back-to-back: one issue per four cycles, busy ticks counted as misses
        clear_logs();
        for (int i = 0; i < 4; i++) push(N'($urandom));
        div = 0;
        run = 1;
        c4  = cyc;
        while (cyc < c4 + 20) begin
            if (cyc == c4 + 1) chk("t6_miss_pre", miss, 0);
            if (cyc == c4 + 2) chk("t6_miss_set", miss, 1);
            @(negedge clk);
        end
        run = 0;
        repeat (2) @(negedge clk);
        check_stream("t6", 4);
        for (int k = 0; k < 4; k++) chk("t6_en_cyc", k < en_cyc.size() ? en_cyc[k] : -1, c4 + 1 + 4 * k);
        chk("t6_ucnt", ucnt, ur(4));
        // Long empty run: underrun counter saturates
        run = 1;
        repeat (300) @(negedge clk);
        run = 0;
        @(negedge clk);
        chk("sat_ucnt", ucnt, ur(300));
        chk("sat_miss", miss, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
